// File: rtl/omem_psum_bank_pkg.sv
// Shared types and default sizing for the per-PE output-memory bank.
// The PE/OMEM records are packed so they can travel as flat port vectors.
package omem_psum_bank_pkg;

   localparam int Q_DW        = 8;
   localparam int IN_CH_NUM   = 64;
   localparam int IN_CH_W     = $clog2(IN_CH_NUM);
   localparam int OMEM_DEPTH  = 64;
   localparam int OMEM_CH_W   = $clog2(OMEM_DEPTH);
   localparam int OMEM_ACC_DW = 2 * Q_DW + IN_CH_W;

   // Field order (msb..lsb) matches the flat pe2omem / omem2pe ports of the bank.
   typedef struct packed {
      logic [OMEM_ACC_DW-1:0] ofmap;
      logic [OMEM_CH_W-1:0]   out_ch;
      logic                   out_valid;
   } pe_to_omem_t;

   typedef struct packed {
      logic [OMEM_ACC_DW-1:0] psum;
      logic                   acc_valid;
   } omem_to_pe_t;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } omem_state_t;

endpackage

// File: rtl/omem_psum_bank_wr_filter.sv
// Turns the PE's held-level output word into a single-cycle write strobe.
// The previous word is tracked every cycle so a stale held word never re-writes.
module omem_wr_filter #(
   parameter int CH_W   = 6,
   parameter int ACC_DW = 22
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              out_valid,
   input  logic [CH_W-1:0]   out_ch,
   input  logic [ACC_DW-1:0] ofmap,
   output logic              wr_stb
);

   logic              prev_valid;
   logic [CH_W-1:0]   prev_ch;
   logic [ACC_DW-1:0] prev_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_valid <= 1'b0;
         prev_ch    <= '0;
         prev_data  <= '0;
      end else begin
         prev_valid <= out_valid;
         prev_ch    <= out_ch;
         prev_data  <= ofmap;
      end
   end

   assign wr_stb = out_valid & (!prev_valid | (out_ch != prev_ch) | (ofmap != prev_data));

endmodule

// File: rtl/omem_psum_bank.sv
// Per-PE output-memory bank: stores finished psums, serves scheduler reads
// back to the PE, and drains every channel to writeback at tile end.
//
// state | meaning
// IDLE  | accepting PE writes and psum reads
// DRAIN | streaming entries 0..OUT_CH_NUM-1; PE writes are dropped
module omem_psum_bank
   import omem_psum_bank_pkg::*;
#(
   parameter int OUT_CH_NUM = OMEM_DEPTH,
   parameter int CH_W       = $clog2(OUT_CH_NUM),
   parameter int ACC_DW     = OMEM_ACC_DW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ACC_DW+CH_W:0]   pe2omem,
   output logic [ACC_DW:0]        omem2pe,
   input  logic                   rd_req,
   input  logic [CH_W-1:0]        rd_ch,
   input  logic                   drain_start,
   output logic                   drain_busy,
   output logic                   drain_done,
   output logic                   dr_valid,
   input  logic                   dr_ready,
   output logic [CH_W-1:0]        dr_ch,
   output logic [ACC_DW-1:0]      dr_data,
   output logic                   dr_last,
   output logic                   wr_drop_err
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(OUT_CH_NUM - 1);

   logic [ACC_DW-1:0] ofmap;
   logic [CH_W-1:0]   out_ch;
   logic              out_valid;

   assign {ofmap, out_ch, out_valid} = pe2omem;

   omem_state_t       state_q, state_d;
   logic [CH_W-1:0]   cnt_q, cnt_d;
   logic              done_d;
   logic              clr_valid;
   logic              wr_stb;
   logic              wr_commit;

   logic [ACC_DW-1:0]     mem [OUT_CH_NUM];
   logic [OUT_CH_NUM-1:0] valid_q;

   logic [ACC_DW-1:0] psum_q;
   logic              acc_valid_q;

   assign omem2pe = {psum_q, acc_valid_q};

   omem_wr_filter #(
      .CH_W   (CH_W),
      .ACC_DW (ACC_DW)
   ) u_wr_filter (
      .clk       (clk),
      .rst       (rst),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .ofmap     (ofmap),
      .wr_stb    (wr_stb)
   );

   assign wr_commit = wr_stb && (state_q == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         drain_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         drain_done <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      clr_valid  = 1'b0;
      drain_busy = 1'b0;
      dr_valid   = 1'b0;
      dr_ch      = '0;
      dr_data    = '0;
      dr_last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (drain_start) state_d = DRAIN;
         end
         DRAIN: begin
            drain_busy = 1'b1;
            dr_valid   = 1'b1;
            dr_ch      = cnt_q;
            dr_last    = (cnt_q == LAST_CH);
            dr_data    = valid_q[cnt_q] ? mem[cnt_q] : '0;
            if (dr_ready) begin
               if (cnt_q == LAST_CH) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  done_d    = 1'b1;
                  clr_valid = 1'b1;
               end else begin
                  cnt_d = cnt_q + CH_W'(1);
               end
            end
         end
      endcase
   end

   // Data array carries no reset; the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      if (wr_commit) mem[out_ch] <= ofmap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (clr_valid) begin
         valid_q <= '0;
      end else if (wr_commit) begin
         valid_q[out_ch] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_drop_err <= 1'b0;
      end else if (wr_stb && (state_q == DRAIN)) begin
         wr_drop_err <= 1'b1;
      end
   end

   // Same-cycle write to the requested channel wins over the stored entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psum_q      <= '0;
         acc_valid_q <= 1'b0;
      end else if (rd_req && (state_q == IDLE)) begin
         if (wr_commit && (out_ch == rd_ch)) begin
            psum_q      <= ofmap;
            acc_valid_q <= 1'b1;
         end else if (valid_q[rd_ch]) begin
            psum_q      <= mem[rd_ch];
            acc_valid_q <= 1'b1;
         end else begin
            psum_q      <= '0;
            acc_valid_q <= 1'b0;
         end
      end else begin
         psum_q      <= '0;
         acc_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_omem_psum_bank.sv
// Directed bench for omem_psum_bank at OUT_CH_NUM = 8: read/bypass vector
// table, then hand-written write-filter, drain, drop-error and reset sequences.
module tb_omem_psum_bank;

   localparam int N  = 8;
   localparam int CW = 3;
   localparam int DW = 22;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW+CW:0] pe2omem;
   logic [DW:0]   omem2pe;
   logic          rd_req = 1'b0;
   logic [CW-1:0] rd_ch = '0;
   logic          drain_start = 1'b0;
   logic          drain_busy, drain_done, dr_valid, dr_last, wr_drop_err;
   logic          dr_ready = 1'b0;
   logic [CW-1:0] dr_ch;
   logic [DW-1:0] dr_data;

   logic          pe_v = 1'b0;
   logic [CW-1:0] pe_ch = '0;
   logic [DW-1:0] pe_d = '0;
   assign pe2omem = {pe_d, pe_ch, pe_v};

   omem_psum_bank #(.OUT_CH_NUM(N), .CH_W(CW), .ACC_DW(DW)) dut (
      .clk(clk), .rst(rst), .pe2omem(pe2omem), .omem2pe(omem2pe),
      .rd_req(rd_req), .rd_ch(rd_ch), .drain_start(drain_start),
      .drain_busy(drain_busy), .drain_done(drain_done),
      .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_ch(dr_ch),
      .dr_data(dr_data), .dr_last(dr_last), .wr_drop_err(wr_drop_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rd(input string name, input logic av, input logic [DW-1:0] ps);
      chk({name, "_acc_valid"}, 32'(omem2pe[0]), 32'(av));
      chk({name, "_psum"}, 32'(omem2pe[DW:1]), 32'(ps));
   endtask

   typedef struct {
      logic          rd;
      logic [CW-1:0] rch;
      logic          wv;
      logic [CW-1:0] wch;
      logic [DW-1:0] wd;
      logic          av;
      logic [DW-1:0] ps;
   } vec_t;

   vec_t vt[12];
   logic [DW-1:0] em[N];

   // Drains with a ready pattern (alternating or constant 1) against model em[].
   task automatic run_drain(input string name, input logic alt);
      logic rdy = 1'b1;
      int   idx = 0;
      logic fin = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
         dr_ready = rdy;
         chk({name, "_dr_valid"}, 32'(dr_valid), 32'd1);
         if (rdy) begin
            chk({name, "_dr_ch"}, 32'(dr_ch), 32'(idx));
            chk({name, "_dr_data"}, 32'(dr_data), 32'(em[idx]));
            chk({name, "_dr_last"}, 32'(dr_last), 32'(idx == N - 1));
            chk({name, "_done_low"}, 32'(drain_done), 32'd0);
            if (idx == N - 1) fin = 1'b1;
            idx++;
         end
         tick();
         if (alt) rdy = !rdy;
      end
      dr_ready = 1'b0;
      chk({name, "_completed"}, 32'(fin), 32'd1);
      chk({name, "_done_pulse"}, 32'(drain_done), 32'd1);
      chk({name, "_busy_off"}, 32'(drain_busy), 32'd0);
      chk({name, "_valid_off"}, 32'(dr_valid), 32'd0);
   endtask

   initial begin
      vt[0]  = '{1'b1, 3'd0, 1'b0, 3'd0, 22'h0,      1'b0, 22'h0};
      vt[1]  = '{1'b0, 3'd0, 1'b1, 3'd5, 22'h1234,   1'b0, 22'h0};
      vt[2]  = '{1'b1, 3'd5, 1'b1, 3'd5, 22'h1234,   1'b1, 22'h1234};
      vt[3]  = '{1'b1, 3'd6, 1'b1, 3'd5, 22'h1234,   1'b0, 22'h0};
      vt[4]  = '{1'b1, 3'd3, 1'b1, 3'd3, 22'h7,      1'b1, 22'h7};
      vt[5]  = '{1'b1, 3'd3, 1'b0, 3'd3, 22'h7,      1'b1, 22'h7};
      vt[6]  = '{1'b1, 3'd0, 1'b0, 3'd0, 22'h0,      1'b0, 22'h0};
      vt[7]  = '{1'b1, 3'd5, 1'b1, 3'd2, 22'h55,     1'b1, 22'h1234};
      vt[8]  = '{1'b0, 3'd0, 1'b0, 3'd0, 22'h0,      1'b0, 22'h0};
      vt[9]  = '{1'b1, 3'd5, 1'b1, 3'd5, 22'h3FFFFF, 1'b1, 22'h3FFFFF};
      vt[10] = '{1'b1, 3'd2, 1'b1, 3'd5, 22'h2AAAAA, 1'b1, 22'h55};
      vt[11] = '{1'b1, 3'd5, 1'b0, 3'd0, 22'h0,      1'b1, 22'h2AAAAA};

      #2 rst = 1'b1;
      #1;
      chk_rd("reset", 1'b0, '0);
      chk("reset_dr_valid", 32'(dr_valid), 32'd0);
      chk("reset_busy", 32'(drain_busy), 32'd0);
      chk("reset_err", 32'(wr_drop_err), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      foreach (vt[i]) begin
         rd_req = vt[i].rd; rd_ch = vt[i].rch;
         pe_v = vt[i].wv; pe_ch = vt[i].wch; pe_d = vt[i].wd;
         tick();
         chk_rd($sformatf("vec%0d", i), vt[i].av, vt[i].ps);
      end
      rd_req = 1'b0; pe_v = 1'b0;

      // Held word written once, drained with alternating ready.
      rst = 1'b1; tick(); rst = 1'b0;
      pe_v = 1'b1; pe_ch = 3'd2; pe_d = 22'h55;
      tick();
      pe_ch = 3'd5; pe_d = 22'h1234;
      for (int i = 0; i < 10; i++) tick();
      foreach (em[i]) em[i] = '0;
      em[2] = 22'h55; em[5] = 22'h1234;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      chk("b_busy", 32'(drain_busy), 32'd1);
      run_drain("b", 1'b1);
      tick();
      chk("b_done_one_cycle", 32'(drain_done), 32'd0);
      chk("b_no_drop", 32'(wr_drop_err), 32'd0);
      rd_req = 1'b1; rd_ch = 3'd5;
      tick();
      chk_rd("b_post_ch5", 1'b0, '0);
      tick();
      chk_rd("b_post_ch5_again", 1'b0, '0);
      rd_ch = 3'd2;
      tick();
      chk_rd("b_post_ch2", 1'b0, '0);
      rd_req = 1'b0;

      // Write together with drain_start is drained; a write during DRAIN is dropped.
      pe_ch = 3'd4; pe_d = 22'h99;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      chk("c_dr_ch0", 32'(dr_ch), 32'd0);
      pe_ch = 3'd6; pe_d = 22'hAB;
      tick();
      chk("c_drop_err", 32'(wr_drop_err), 32'd1);
      chk("c_held_ch", 32'(dr_ch), 32'd0);
      foreach (em[i]) em[i] = '0;
      em[4] = 22'h99;
      run_drain("c", 1'b0);
      chk("c_drop_sticky", 32'(wr_drop_err), 32'd1);
      rd_req = 1'b1; rd_ch = 3'd6;
      tick();
      chk_rd("c_post_ch6", 1'b0, '0);
      rd_ch = 3'd4;
      tick();
      chk_rd("c_post_ch4", 1'b0, '0);
      rd_req = 1'b0;

      // Reset during beat 3 of a drain.
      pe_ch = 3'd1; pe_d = 22'h11;
      tick();
      pe_v = 1'b0;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      dr_ready = 1'b1;
      tick(); tick(); tick();
      chk("d_beat3", 32'(dr_ch), 32'd3);
      rst = 1'b1;
      #1;
      chk("d_rst_dr_valid", 32'(dr_valid), 32'd0);
      chk("d_rst_busy", 32'(drain_busy), 32'd0);
      chk("d_rst_dr_ch", 32'(dr_ch), 32'd0);
      chk("d_rst_err", 32'(wr_drop_err), 32'd0);
      tick();
      rst = 1'b0; dr_ready = 1'b0;
      rd_req = 1'b1; rd_ch = 3'd1;
      tick();
      chk_rd("d_post_ch1", 1'b0, '0);
      rd_req = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
